// File: rtl/filter_read_addr_seq.sv
// Read-address sequencer for the conv PE filter scratchpad.
// Walks num_filters consecutive filters of filter_size words from base_addr,
// one address per valid/ready handshake, with end-of-filter / end-of-run flags.
// Optional feature macro: FILTER_REPEAT_EN (re-reads each filter repeat_cnt extra times).
module filter_read_addr_seq #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned FSIZE_W = 8,
    parameter int unsigned NFILT_W = 4
`ifdef FILTER_REPEAT_EN
    ,
    parameter int unsigned REP_W   = 4
`endif
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic [ADDR_W-1:0]  base_addr_i,
    input  logic [FSIZE_W-1:0] filter_size_i,
    input  logic [NFILT_W-1:0] num_filters_i,
`ifdef FILTER_REPEAT_EN
    input  logic [REP_W-1:0]   repeat_cnt_i,
`endif
    input  logic               addr_ready_i,
    output logic [ADDR_W-1:0]  addr_o,
    output logic               addr_valid_o,
    output logic               last_in_filter_o,
    output logic               last_filter_o,
    output logic [NFILT_W-1:0] filter_idx_o,
    output logic               busy_o,
    output logic               done_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  base_q, base_d;
    logic [FSIZE_W-1:0] fs_q, fs_d;
    logic [NFILT_W-1:0] nf_q, nf_d;
    logic [ADDR_W-1:0]  offset_q, offset_d;
    logic [FSIZE_W-1:0] point_q, point_d;
    logic [NFILT_W-1:0] fidx_q, fidx_d;
`ifdef FILTER_REPEAT_EN
    logic [REP_W-1:0]   rep_q, rep_d;
    logic [REP_W-1:0]   rep_max_q, rep_max_d;
`endif

    logic run_s;
    logic pt_last_s;
    logic fl_last_s;
    logic rep_more_s;

    assign run_s     = (state_q == S_RUN);
    assign pt_last_s = (point_q == (fs_q - FSIZE_W'(1)));
    assign fl_last_s = (fidx_q == (nf_q - NFILT_W'(1)));
`ifdef FILTER_REPEAT_EN
    assign rep_more_s = (rep_q < rep_max_q);
`else
    assign rep_more_s = 1'b0;
`endif

    // Outputs decode registered state only; addr_ready never reaches addr.
    assign addr_o           = run_s ? (base_q + offset_q + ADDR_W'(point_q)) : {ADDR_W{1'b0}};
    assign addr_valid_o     = run_s;
    assign last_in_filter_o = run_s & pt_last_s;
    assign last_filter_o    = run_s & fl_last_s;
    assign filter_idx_o     = fidx_q;
    assign busy_o           = (state_q != S_IDLE);
    assign done_o           = (state_q == S_DONE);

    // State and counter registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            base_q    <= {ADDR_W{1'b0}};
            fs_q      <= {FSIZE_W{1'b0}};
            nf_q      <= {NFILT_W{1'b0}};
            offset_q  <= {ADDR_W{1'b0}};
            point_q   <= {FSIZE_W{1'b0}};
            fidx_q    <= {NFILT_W{1'b0}};
`ifdef FILTER_REPEAT_EN
            rep_q     <= {REP_W{1'b0}};
            rep_max_q <= {REP_W{1'b0}};
`endif
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            fs_q      <= fs_d;
            nf_q      <= nf_d;
            offset_q  <= offset_d;
            point_q   <= point_d;
            fidx_q    <= fidx_d;
`ifdef FILTER_REPEAT_EN
            rep_q     <= rep_d;
            rep_max_q <= rep_max_d;
`endif
        end
    end

    // Next-state logic: abort wins, then start (IDLE only), then handshakes (RUN only).
    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        fs_d      = fs_q;
        nf_d      = nf_q;
        offset_d  = offset_q;
        point_d   = point_q;
        fidx_d    = fidx_q;
`ifdef FILTER_REPEAT_EN
        rep_d     = rep_q;
        rep_max_d = rep_max_q;
`endif
        if (abort_i) begin
            state_d  = S_IDLE;
            offset_d = {ADDR_W{1'b0}};
            point_d  = {FSIZE_W{1'b0}};
            fidx_d   = {NFILT_W{1'b0}};
`ifdef FILTER_REPEAT_EN
            rep_d    = {REP_W{1'b0}};
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        base_d   = base_addr_i;
                        fs_d     = filter_size_i;
                        nf_d     = num_filters_i;
                        offset_d = {ADDR_W{1'b0}};
                        point_d  = {FSIZE_W{1'b0}};
                        fidx_d   = {NFILT_W{1'b0}};
`ifdef FILTER_REPEAT_EN
                        rep_d     = {REP_W{1'b0}};
                        rep_max_d = repeat_cnt_i;
`endif
                        // An empty run issues no addresses but still reports completion.
                        if ((filter_size_i == {FSIZE_W{1'b0}}) || (num_filters_i == {NFILT_W{1'b0}})) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_RUN;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_RUN: begin
                    if (addr_ready_i) begin
                        if (!pt_last_s) begin
                            point_d = point_q + FSIZE_W'(1);
                        end else if (rep_more_s) begin
                            // Another pass over the same filter.
                            point_d = {FSIZE_W{1'b0}};
`ifdef FILTER_REPEAT_EN
                            rep_d   = rep_q + REP_W'(1);
`endif
                        end else begin
                            point_d = {FSIZE_W{1'b0}};
`ifdef FILTER_REPEAT_EN
                            rep_d   = {REP_W{1'b0}};
`endif
                            if (fl_last_s) begin
                                state_d  = S_DONE;
                                offset_d = {ADDR_W{1'b0}};
                                fidx_d   = {NFILT_W{1'b0}};
                            end else begin
                                offset_d = offset_q + ADDR_W'(fs_q);
                                fidx_d   = fidx_q + NFILT_W'(1);
                            end
                        end
                    end else begin
                        state_d = S_RUN;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_filter_read_addr_seq.sv
// Self-checking bench for filter_read_addr_seq: directed and randomized runs
// compared against an address list built from nested filter/pass/point loops.
module tb_filter_read_addr_seq;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       start_i = 1'b0;
    logic       abort_i = 1'b0;
    logic [7:0] base_addr_i = 8'd0;
    logic [7:0] filter_size_i = 8'd0;
    logic [3:0] num_filters_i = 4'd0;
`ifdef FILTER_REPEAT_EN
    logic [3:0] repeat_cnt_i = 4'd0;
`endif
    logic       addr_ready_i = 1'b0;
    logic [7:0] addr_o;
    logic       addr_valid_o;
    logic       last_in_filter_o;
    logic       last_filter_o;
    logic [3:0] filter_idx_o;
    logic       busy_o;
    logic       done_o;

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct {
        int addr;
        int lif;
        int lf;
        int fidx;
    } exp_t;

    filter_read_addr_seq dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .start_i          (start_i),
        .abort_i          (abort_i),
        .base_addr_i      (base_addr_i),
        .filter_size_i    (filter_size_i),
        .num_filters_i    (num_filters_i),
`ifdef FILTER_REPEAT_EN
        .repeat_cnt_i     (repeat_cnt_i),
`endif
        .addr_ready_i     (addr_ready_i),
        .addr_o           (addr_o),
        .addr_valid_o     (addr_valid_o),
        .last_in_filter_o (last_in_filter_o),
        .last_filter_o    (last_filter_o),
        .filter_idx_o     (filter_idx_o),
        .busy_o           (busy_o),
        .done_o           (done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total_cnt++;
        assert (obs === expv) pass_cnt++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, 32'(addr_valid_o), 32'd0);
        chk({tag, "_busy"},  32'(busy_o),       32'd0);
        chk({tag, "_done"},  32'(done_o),       32'd0);
        chk({tag, "_addr"},  32'(addr_o),       32'd0);
        chk({tag, "_fidx"},  32'(filter_idx_o), 32'd0);
        chk({tag, "_lif"},   32'(last_in_filter_o), 32'd0);
        chk({tag, "_lf"},    32'(last_filter_o),    32'd0);
    endtask

    // mode: 0 ready always, 1 ready pattern 1,0,0, 2 random ready.
    // abort_at: number of accepted addresses after which abort is raised (-1 = never).
    task automatic run_cfg(input int base, input int fs, input int nf, input int rp,
                           input int mode, input int abort_at);
        exp_t q[$];
        exp_t e;
        int   cyc;
        int   pops;
        bit   ended;
        bit   rdy;
        q = {};
        for (int f = 0; f < nf; f++)
            for (int r = 0; r <= rp; r++)
                for (int p = 0; p < fs; p++) begin
                    e.addr = (base + f * fs + p) % 256;
                    e.lif  = (p == fs - 1) ? 1 : 0;
                    e.lf   = (f == nf - 1) ? 1 : 0;
                    e.fidx = f;
                    q.push_back(e);
                end
        base_addr_i   = 8'(base);
        filter_size_i = 8'(fs);
        num_filters_i = 4'(nf);
`ifdef FILTER_REPEAT_EN
        repeat_cnt_i  = 4'(rp);
`endif
        start_i      = 1'b1;
        addr_ready_i = 1'b0;
        @(negedge clk_i);
        start_i = 1'b0;
        pops  = 0;
        cyc   = 0;
        ended = 1'b0;
        while (!ended && cyc < 4000) begin
            if (q.size() > 0) begin
                chk("valid", 32'(addr_valid_o), 32'd1);
                chk("addr",  32'(addr_o), 32'(q[0].addr));
                chk("lif",   32'(last_in_filter_o), 32'(q[0].lif));
                chk("lf",    32'(last_filter_o), 32'(q[0].lf));
                chk("fidx",  32'(filter_idx_o), 32'(q[0].fidx));
                chk("busy",  32'(busy_o), 32'd1);
                chk("done_run", 32'(done_o), 32'd0);
                if (pops == abort_at) begin
                    abort_i      = 1'b1;
                    addr_ready_i = 1'b1;
                    start_i      = 1'b1;
                    @(negedge clk_i);
                    abort_i      = 1'b0;
                    addr_ready_i = 1'b0;
                    start_i      = 1'b0;
                    chk_idle("abort");
                    repeat (3) begin
                        @(negedge clk_i);
                        chk("abort_nodone", 32'(done_o), 32'd0);
                    end
                    ended = 1'b1;
                end else begin
                    case (mode)
                        0: rdy = 1'b1;
                        1: rdy = ((cyc % 3) == 0);
                        default: rdy = 1'($urandom % 2);
                    endcase
                    addr_ready_i = rdy;
                    start_i      = 1'($urandom % 2);
                    if (rdy) begin
                        void'(q.pop_front());
                        pops++;
                    end
                    @(negedge clk_i);
                end
            end else begin
                start_i      = 1'b0;
                addr_ready_i = 1'b0;
                chk("done_pulse", 32'(done_o), 32'd1);
                chk("done_valid", 32'(addr_valid_o), 32'd0);
                chk("done_busy",  32'(busy_o), 32'd1);
                chk("done_lif",   32'(last_in_filter_o), 32'd0);
                @(negedge clk_i);
                chk_idle("after_done");
                ended = 1'b1;
            end
            cyc++;
        end
        if (!ended) chk("timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int b, fs, nf, md, ab, rp;
        // Reset state
        #3;
        chk_idle("reset");
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        chk_idle("post_reset");

        // Basic walk, stalls, wrap, empty runs
        run_cfg(10, 3, 2, 0, 0, -1);
        run_cfg(10, 3, 2, 0, 1, -1);
        run_cfg(254, 4, 1, 0, 0, -1);
        run_cfg(5, 0, 2, 0, 0, -1);
        run_cfg(5, 3, 0, 0, 0, -1);
        run_cfg(7, 1, 3, 0, 2, -1);

        // Abort after second handshake, then a fresh run
        run_cfg(10, 3, 2, 0, 0, 2);
        run_cfg(10, 3, 2, 0, 0, -1);

        // Abort in IDLE wins over start
        abort_i = 1'b1;
        start_i = 1'b1;
        @(negedge clk_i);
        abort_i = 1'b0;
        start_i = 1'b0;
        chk_idle("abort_idle");

        // Asynchronous reset mid-run
        base_addr_i   = 8'd10;
        filter_size_i = 8'd3;
        num_filters_i = 4'd2;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i      = 1'b0;
        addr_ready_i = 1'b1;
        repeat (2) @(negedge clk_i);
        #2 rst_i = 1'b1;
        #1 chk_idle("rst_mid");
        @(negedge clk_i);
        rst_i        = 1'b0;
        addr_ready_i = 1'b0;
        @(negedge clk_i);
        chk_idle("rst_after");
        run_cfg(10, 3, 2, 0, 0, -1);

`ifdef FILTER_REPEAT_EN
        run_cfg(0, 2, 2, 1, 0, -1);
        run_cfg(100, 3, 2, 2, 2, -1);
`endif

        // Randomized runs
        for (int i = 0; i < 20; i++) begin
            b  = int'($urandom_range(0, 255));
            fs = int'($urandom_range(0, 6));
            nf = int'($urandom_range(0, 4));
            md = int'($urandom_range(0, 2));
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : -1;
`ifdef FILTER_REPEAT_EN
            rp = int'($urandom_range(0, 2));
`else
            rp = 0;
`endif
            if (ab >= fs * nf * (rp + 1)) ab = -1;
            run_cfg(b, fs, nf, rp, md, ab);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
